// File: rtl/sync_fifo_stream_reader.sv
`timescale 1ns/1ps
// sync_fifo_stream_reader
//
// Consumer-side engine for a synchronous FIFO with a 1-cycle registered read
// port. Issues FIFO reads into a 3-entry skid buffer. That is enough to cover
// one word in flight plus the word being presented, so the block can stream at
// one word per cycle without making fifo_rq depend on m_ready. Output is a
// valid/ready stream with a last-beat marker every PKT_LEN words.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high, dominates everything
//   fifo_rd_data  FIFO read data, valid the cycle after an accepted read
//   fifo_empty    FIFO empty flag
//   fifo_rq       FIFO read request (combinational)
//   flush         synchronous clear of buffered data, in-flight read, framing
//   m_data        stream data (zero while m_valid is low)
//   m_valid       stream valid
//   m_ready       stream ready
//   m_last        last beat of packet, qualified by m_valid
//   pkt_done      1-cycle pulse after a last-beat handshake
//   word_cnt      words handshaked since reset/flush, wraps
module sync_fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int CNT_WIDTH  = 4,
  parameter int WC_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rq,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  pkt_done,
  output logic [WC_WIDTH-1:0]   word_cnt
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] skid_mem [0:2];
  logic [1:0]            head_ptr;
  logic [1:0]            tail_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [2:0]            fill;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffered words plus the one on its way from the FIFO; never request
  // more than the buffer can absorb even if the sink stalls indefinitely.
  assign fill    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rq = !rst && !flush && !fifo_empty && (fill < 3'd3);

  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? skid_mem[head_ptr] : '0;
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

  assign pop  = m_valid && m_ready;
  // A read landing on a flush or reset edge is discarded.
  assign push = inflight && !flush && !rst;

  always_ff @(posedge clk) begin
    if (push) begin
      skid_mem[tail_ptr] <= fifo_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head_ptr <= 2'd0;
      tail_ptr <= 2'd0;
      beat_cnt <= '0;
      word_cnt <= '0;
      pkt_done <= 1'b0;
    end else begin
      inflight <= fifo_rq && !fifo_empty;
      pkt_done <= pop && m_last;

      if (push) begin
        tail_ptr <= ptr_inc(tail_ptr);
      end

      if (pop) begin
        head_ptr <= ptr_inc(head_ptr);
        word_cnt <= word_cnt + WC_WIDTH'(1);
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
      end

      // Simultaneous push and pop keeps occupancy; with occ=1 the new word
      // simply becomes the head on the next cycle, so there is no bubble.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
`timescale 1ns/1ps
module tb_sync_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty;
  logic        fifo_rq;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        pkt_done;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  sync_fifo_stream_reader #(
    .DATA_WIDTH(8), .PKT_LEN(16), .CNT_WIDTH(4), .WC_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rq(fifo_rq), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .pkt_done(pkt_done), .word_cnt(word_cnt)
  );

  // Behavioural sync FIFO: 1-cycle registered read, data held until next read.
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rq && !fifo_empty) begin
      fifo_rd_data <= fifo_mem[rd_ptr[9:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Monitor, sampled at the falling edge so inputs and outputs are settled.
  int   rq_cnt = 0;
  int   pd_cnt = 0;
  int   rq_empty_err = 0;
  int   occ_err = 0;
  int   valid_err = 0;
  int   mdl_occ = 0;
  int   mdl_inf = 0;
  bit   mon_on = 1'b0;
  logic [7:0] got_q [$];
  logic       got_last_q [$];

  always @(negedge clk) begin
    if (mon_on) begin
      if (m_valid !== (mdl_occ != 0)) valid_err <= valid_err + 1;
      if (fifo_rq && fifo_empty)      rq_empty_err <= rq_empty_err + 1;
      if (fifo_rq)                    rq_cnt <= rq_cnt + 1;
      if (pkt_done)                   pd_cnt <= pd_cnt + 1;
      if (mdl_occ > 3)                occ_err <= occ_err + 1;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
      end
    end
    if (rst || flush) begin
      mdl_occ <= 0;
      mdl_inf <= 0;
    end else begin
      mdl_occ <= mdl_occ + mdl_inf - ((m_valid && m_ready) ? 1 : 0);
      mdl_inf <= (fifo_rq && !fifo_empty) ? 1 : 0;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] v);
    fifo_mem[wr_ptr[9:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    int pd_base;
    int rq_base;
    int got_base;
    int wrote;
    int cyc;
    int mism;
    logic [7:0] v;
    logic [7:0] exp_q [$];

    // Reset
    tick();
    tick();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_last", m_last, 1'b0);
    check("rst_pkt_done", pkt_done, 1'b0);
    check("rst_word_cnt", word_cnt, 16'd0);
    check("rst_fifo_rq", fifo_rq, 1'b0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // Streaming 32 words with m_ready held high
    pd_base = pd_cnt;
    m_ready = 1'b1;
    for (int i = 0; i < 32; i++) push_word(8'(i));
    #1;
    check("stream_rq_first", fifo_rq, 1'b1);
    check("stream_valid_c0", m_valid, 1'b0);
    tick();
    check("stream_valid_c1", m_valid, 1'b0);
    tick();
    for (int i = 0; i < 32; i++) begin
      check("stream_valid", m_valid, 1'b1);
      check("stream_data", m_data, 8'(i));
      check("stream_last", m_last, (i == 15 || i == 31) ? 1'b1 : 1'b0);
      check("stream_word_cnt", word_cnt, 16'(i));
      check("stream_pkt_done", pkt_done, (i == 16) ? 1'b1 : 1'b0);
      tick();
    end
    check("stream_pkt_done_end", pkt_done, 1'b1);
    check("stream_word_cnt_end", word_cnt, 16'd32);
    check("stream_valid_end", m_valid, 1'b0);
    tick();
    check("stream_pkt_done_pulses", pd_cnt - pd_base, 2);

    // Backpressure: 10 words queued, sink stalled for 20 cycles
    m_ready = 1'b0;
    rq_base = rq_cnt;
    for (int i = 0; i < 10; i++) push_word(8'(i));
    for (int i = 0; i < 10; i++) tick();
    check("bp_data_hold_mid", m_data, 8'h00);
    for (int i = 0; i < 10; i++) tick();
    check("bp_rq_pulses", rq_cnt - rq_base, 3);
    check("bp_valid", m_valid, 1'b1);
    check("bp_data_hold", m_data, 8'h00);
    check("bp_rq_idle", fifo_rq, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_drain_valid", m_valid, 1'b1);
      check("bp_drain_data", m_data, 8'(i));
      check("bp_drain_last", m_last, 1'b0);
      tick();
    end
    check("bp_end_valid", m_valid, 1'b0);
    check("bp_end_word_cnt", word_cnt, 16'd42);

    // Empty boundary: single word into an empty FIFO
    rq_base = rq_cnt;
    push_word(8'hA5);
    #1;
    check("empty_rq_issue", fifo_rq, 1'b1);
    tick();
    check("empty_rq_after", fifo_rq, 1'b0);
    check("empty_valid_c1", m_valid, 1'b0);
    tick();
    check("empty_valid", m_valid, 1'b1);
    check("empty_data", m_data, 8'hA5);
    tick();
    check("empty_valid_after", m_valid, 1'b0);
    check("empty_rq_idle", fifo_rq, 1'b0);
    check("empty_word_cnt", word_cnt, 16'd43);
    check("empty_rq_pulses", rq_cnt - rq_base, 1);

    // Flush mid-packet with a read in flight
    for (int i = 0; i < 40; i++) push_word(8'(8'h40 + i));
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("fl_pre_data", m_data, 8'(8'h40 + i));
      tick();
    end
    check("fl_head_before", m_data, 8'h45);
    check("fl_word_cnt_before", word_cnt, 16'd48);
    m_ready = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_rq_during", fifo_rq, 1'b0);
    tick();
    check("fl_valid_after", m_valid, 1'b0);
    check("fl_word_cnt", word_cnt, 16'd0);
    check("fl_pkt_done", pkt_done, 1'b0);
    flush = 1'b0;
    m_ready = 1'b1;
    tick();
    check("fl_valid_c9", m_valid, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check("fl_post_valid", m_valid, 1'b1);
      check("fl_post_data", m_data, 8'(8'h47 + i));
      check("fl_post_last", m_last, (i == 15) ? 1'b1 : 1'b0);
      check("fl_post_word_cnt", word_cnt, 16'(i));
      tick();
    end
    check("fl_pkt_done_pulse", pkt_done, 1'b1);

    // Reset while the skid buffer is full
    m_ready = 1'b0;
    tick();
    tick();
    tick();
    check("rm_full_valid", m_valid, 1'b1);
    check("rm_full_data", m_data, 8'h57);
    check("rm_full_rq", fifo_rq, 1'b0);
    rst = 1'b1;
    #1;
    check("rm_rq_in_rst", fifo_rq, 1'b0);
    tick();
    check("rm_valid", m_valid, 1'b0);
    check("rm_data", m_data, 8'h00);
    check("rm_last", m_last, 1'b0);
    check("rm_pkt_done", pkt_done, 1'b0);
    check("rm_word_cnt", word_cnt, 16'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    check("rm_rq_resume", fifo_rq, 1'b1);
    tick();
    check("rm_valid_c1", m_valid, 1'b0);
    tick();
    check("rm_next_valid", m_valid, 1'b1);
    check("rm_next_data", m_data, 8'h5A);
    for (int i = 0; i < 20; i++) tick();
    check("rm_drain_word_cnt", word_cnt, 16'd14);
    check("rm_drain_valid", m_valid, 1'b0);

    // Random ready and sporadic writes, 500 words
    m_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    got_base = got_q.size();
    wrote = 0;
    cyc = 0;
    while ((got_q.size() - got_base) < 500 && cyc < 8000) begin
      if (wrote < 500 && $urandom_range(0, 2) != 0) begin
        v = 8'($urandom_range(0, 255));
        push_word(v);
        exp_q.push_back(v);
        wrote++;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("rand_count", got_q.size() - got_base, 500);
    check("rand_word_cnt", word_cnt, 16'd500);
    mism = 0;
    for (int k = 0; k < 500 && (got_base + k) < got_q.size(); k++) begin
      if (got_q[got_base + k] !== exp_q[k]) mism++;
      if (got_last_q[got_base + k] !== ((k % 16) == 15)) mism++;
    end
    check("rand_data_last", mism, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    check("rq_while_empty", rq_empty_err, 0);
    check("occ_bound", occ_err, 0);
    check("valid_vs_occ", valid_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
